residue_engine: RTL and testbench

Parametrised serial residue engine: accepts a binary number as a stream of DIGIT_W-bit digits and maintains its running residue modulo MODULUS, with framing, a divisibility flag and a digit counter. Generalises the single-bit, fixed-modulus residue machine to any modulus, multi-bit digits per clock, and explicit frame boundaries. Sits behind a serial front end that delivers one digit per accepted cycle.

---
 rtl/residue_engine.sv | 117 +++++++++++
 tb/tb_residue_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/residue_engine.sv
// Serial residue engine: running value of a digit stream modulo MODULUS, with framing and counting.
// Define RESIDUE_LSB_FIRST_EN for least-significant-digit-first streams (adds a weight register).
module residue_engine #(
  parameter int MODULUS = 5,
  parameter int RW      = 3,
  parameter int DIGIT_W = 1,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               last,
  output logic [RW-1:0]      residue,
  output logic               divisible,
  output logic [LEN_W-1:0]   count,
  output logic               count_sat,
  output logic               done,
  output logic               busy
);

  // One spare bit so base + digit*w (LSB-first) also reduces without truncation.
  localparam int IW = RW + DIGIT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  function automatic logic [RW-1:0] f_mod(input logic [IW-1:0] x);
    return RW'(x % IW'(MODULUS));
  endfunction

  function automatic logic [LEN_W-1:0] f_sat_inc(input logic [LEN_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RW-1:0]      r_residue;
  logic               r_div;
  logic [LEN_W-1:0]   r_count;
  logic               r_sat;
  logic               r_done;
  logic               w_start;
  logic [RW-1:0]      w_base;
  logic [RW-1:0]      w_res_nxt;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic               w_sat_nxt;
`ifdef RESIDUE_LSB_FIRST_EN
  logic [RW-1:0]      r_wt;
  logic [RW-1:0]      w_wt;
  logic [RW-1:0]      w_wt_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = (r_state != S_ACCUM);
    w_base      = w_start ? '0 : r_residue;
    w_cnt_nxt   = w_start ? LEN_W'(1) : f_sat_inc(r_count);
    w_sat_nxt   = w_start ? 1'b0 : (r_sat | (r_count == '1));
`ifdef RESIDUE_LSB_FIRST_EN
    // Weight restarts at 1 (MODULUS >= 2) on every frame's first digit.
    w_wt        = w_start ? RW'(1) : r_wt;
    w_res_nxt   = f_mod(IW'(w_base) + IW'(digit) * IW'(w_wt));
    w_wt_nxt    = f_mod(IW'(w_wt) << DIGIT_W);
`else
    w_res_nxt   = f_mod({1'b0, w_base, digit});
`endif
    if (clear)         w_state_nxt = S_IDLE;
    else if (in_valid) w_state_nxt = last ? S_HOLD : S_ACCUM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_residue <= '0;
      r_div     <= 1'b0;
      r_count   <= '0;
      r_sat     <= 1'b0;
      r_done    <= 1'b0;
`ifdef RESIDUE_LSB_FIRST_EN
      r_wt      <= RW'(1);
`endif
    end else if (clear) begin
      r_residue <= '0;
      r_div     <= 1'b0;
      r_count   <= '0;
      r_sat     <= 1'b0;
      r_done    <= 1'b0;
`ifdef RESIDUE_LSB_FIRST_EN
      r_wt      <= RW'(1);
`endif
    end else begin
      r_done <= in_valid & last;
      if (in_valid) begin
        r_residue <= w_res_nxt;
        r_div     <= (w_res_nxt == '0);
        r_count   <= w_cnt_nxt;
        r_sat     <= w_sat_nxt;
`ifdef RESIDUE_LSB_FIRST_EN
        r_wt      <= w_wt_nxt;
`endif
      end
    end
  end

  assign residue   = r_residue;
  assign divisible = r_div;
  assign count     = r_count;
  assign count_sat = r_sat;
  assign done      = r_done;
  assign busy      = (r_state == S_ACCUM);

endmodule

// File: tb/tb_residue_engine.sv
// Bench for residue_engine: table vectors, corner sequences and a randomized reference model.
module tb_residue_engine;

`ifdef RESIDUE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 0, l0 = 0, c0 = 0;
  logic [0:0] d0 = '0;
  logic       v1 = 0, l1 = 0, c1 = 0;
  logic [1:0] d1 = '0;
  logic [2:0] r0, r1;
  logic [7:0] cn0;
  logic [2:0] cn1;
  logic       dv0, st0, dn0, bs0, dv1, st1, dn1, bs1;

  int n_vec = 0;
  int n_err = 0;

  residue_engine #(.MODULUS(5), .RW(3), .DIGIT_W(1), .LEN_W(8)) u0 (
    .clk(clk), .reset(rst), .clear(c0), .in_valid(v0), .digit(d0), .last(l0),
    .residue(r0), .divisible(dv0), .count(cn0), .count_sat(st0), .done(dn0), .busy(bs0));

  residue_engine #(.MODULUS(7), .RW(3), .DIGIT_W(2), .LEN_W(3)) u1 (
    .clk(clk), .reset(rst), .clear(c1), .in_valid(v1), .digit(d1), .last(l1),
    .residue(r1), .divisible(dv1), .count(cn1), .count_sat(st1), .done(dn1), .busy(bs1));

  always #5 clk = ~clk;

  // Reference model: digits of the current frame, residue from positional weights.
  int md [2][0:255];
  int m_len [2];
  bit m_acc [2];
  int m_res [2];
  bit m_dv [2];
  int m_cnt [2];
  bit m_sat [2];
  bit m_dn [2];

  function automatic int powmod(int b, int e, int m);
    int r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_len[k] = 0; m_acc[k] = 0; m_res[k] = 0; m_dv[k] = 0;
      m_cnt[k] = 0; m_sat[k] = 0; m_dn[k] = 0;
    end
  endtask

  task automatic mstep(input int k, input bit v, input bit l, input bit c, input int d);
    int m, b, cmax, s, pos;
    m    = (k == 0) ? 5 : 7;
    b    = (k == 0) ? 2 : 4;
    cmax = (k == 0) ? 255 : 7;
    if (c) begin
      m_len[k] = 0; m_acc[k] = 0; m_res[k] = 0; m_dv[k] = 0;
      m_cnt[k] = 0; m_sat[k] = 0; m_dn[k] = 0;
    end else begin
      m_dn[k] = v && l;
      if (v) begin
        if (!m_acc[k]) begin
          m_len[k] = 0; m_cnt[k] = 1; m_sat[k] = 0;
        end else if (m_cnt[k] == cmax) m_sat[k] = 1;
        else m_cnt[k]++;
        md[k][m_len[k]] = d;
        m_len[k]++;
        s = 0;
        for (int i = 0; i < m_len[k]; i++) begin
          pos = LSB ? i : (m_len[k] - 1 - i);
          s = (s + md[k][i] * powmod(b, pos, m)) % m;
        end
        m_res[k] = s;
        m_dv[k]  = (s == 0);
        m_acc[k] = !l;
      end
    end
  endtask

  task automatic cyc(input bit av, input bit al, input bit ac, input int ad,
                     input bit bv, input bit bl, input bit bc, input int bd);
    v0 = av; l0 = al; c0 = ac; d0 = ad[0:0];
    v1 = bv; l1 = bl; c1 = bc; d1 = bd[1:0];
    mstep(0, av, al, ac, ad);
    mstep(1, bv, bl, bc, bd);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int k, input string nm, input int res, input bit dv,
                     input int cnt, input bit sat, input bit dn, input bit bs);
    logic [31:0] ar, ac;
    logic [3:0]  af;
    if (k == 0) begin ar = 32'(r0); ac = 32'(cn0); af = {dv0, st0, dn0, bs0}; end
    else        begin ar = 32'(r1); ac = 32'(cn1); af = {dv1, st1, dn1, bs1}; end
    n_vec++;
    if (ar !== res || ac !== cnt || af !== {dv, sat, dn, bs}) begin
      n_err++;
      $display("FAIL %s u%0d: got res=%0d cnt=%0d div/sat/done/busy=%b, want res=%0d cnt=%0d div/sat/done/busy=%b",
               nm, k, ar, ac, af, res, cnt, {dv, sat, dn, bs});
    end
  endtask

  task automatic chkm(input int k, input string nm);
    chk(k, nm, m_res[k], m_dv[k], m_cnt[k], m_sat[k], m_dn[k], m_acc[k]);
  endtask

  typedef struct {
    bit v; bit l; bit c; int d;
    int res; bit dv; int cnt; bit sat; bit dn; bit bs;
  } vec_t;

  vec_t tbl [32];
  int   ntbl;

  task automatic add(input bit v, input bit l, input bit c, input int d, input int res,
                     input bit dv, input int cnt, input bit dn, input bit bs);
    tbl[ntbl] = '{v, l, c, d, res, dv, cnt, 1'b0, dn, bs};
    ntbl++;
  endtask

  initial begin
    bit rv, rl, rc;
    ntbl = 0;
`ifdef RESIDUE_LSB_FIRST_EN
    // 42 least-significant digit first
    add(1,0,0,0, 0,1,1,0,1); add(1,0,0,1, 2,0,2,0,1); add(1,0,0,0, 2,0,3,0,1);
    add(1,0,0,1, 0,1,4,0,1); add(1,0,0,0, 0,1,5,0,1); add(1,1,0,1, 2,0,6,1,0);
    add(0,0,0,0, 2,0,6,0,0);
    // 45
    add(1,0,0,1, 1,0,1,0,1); add(1,0,0,0, 1,0,2,0,1); add(1,0,0,1, 0,1,3,0,1);
    add(1,0,0,1, 3,0,4,0,1); add(1,0,0,0, 3,0,5,0,1); add(1,1,0,1, 0,1,6,1,0);
`else
    // 42 most-significant digit first
    add(1,0,0,1, 1,0,1,0,1); add(1,0,0,0, 2,0,2,0,1); add(1,0,0,1, 0,1,3,0,1);
    add(1,0,0,0, 0,1,4,0,1); add(1,0,0,1, 1,0,5,0,1); add(1,1,0,0, 2,0,6,1,0);
    add(0,0,0,0, 2,0,6,0,0);
    // 45
    add(1,0,0,1, 1,0,1,0,1); add(1,0,0,0, 2,0,2,0,1); add(1,0,0,1, 0,1,3,0,1);
    add(1,0,0,1, 1,0,4,0,1); add(1,0,0,0, 2,0,5,0,1); add(1,1,0,1, 0,1,6,1,0);
`endif
    // 7 back-to-back, then clear with a digit, then a two-digit frame
    add(1,0,0,1, 1,0,1,0,1); add(1,0,0,1, 3,0,2,0,1); add(1,1,0,1, 2,0,3,1,0);
    add(0,0,0,0, 2,0,3,0,0);
    add(1,0,1,1, 0,0,0,0,0);
    add(1,0,0,1, 1,0,1,0,1); add(1,1,0,1, 3,0,2,1,0);
    add(0,1,0,0, 3,0,2,0,0);

    mreset();
    #12;
    chk(0, "reset_state", 0, 0, 0, 0, 0, 0);
    chk(1, "reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < ntbl; i++) begin
      cyc(tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].d, 0, 0, 0, 0);
      chk(0, $sformatf("tbl%0d", i), tbl[i].res, tbl[i].dv, tbl[i].cnt,
          tbl[i].sat, tbl[i].dn, tbl[i].bs);
    end

    // Modulus 7, two-bit digits: 42 = 2,2,2 in base 4 (same residues either order)
    cyc(0,0,0,0, 1,0,0,2); chk(1, "m7_d0", 2, 0, 1, 0, 0, 1);
    cyc(0,0,0,0, 1,0,0,2); chk(1, "m7_d1", 3, 0, 2, 0, 0, 1);
    cyc(0,0,0,0, 1,1,0,2); chk(1, "m7_d2", 0, 1, 3, 0, 1, 0);
    cyc(0,0,0,0, 0,0,0,0); chk(1, "m7_after", 0, 1, 3, 0, 0, 0);

    // Nine-digit frame against a three-bit counter
    for (int i = 0; i < 9; i++) begin
      cyc(0,0,0,0, 1, (i == 8), 0, 1);
      chkm(1, $sformatf("sat_d%0d", i));
    end
    chk(1, "sat_final", 0, 1, 7, 1, 1, 0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) cyc(1,0,0,1, 0,0,0,0);
    #3;
    rst = 1'b1;
    #1;
    chk(0, "async_rst", 0, 0, 0, 0, 0, 0);
    mreset();
    rst = 1'b0;
    cyc(0,0,0,0, 0,0,0,0);
    chk(0, "rst_no_done", 0, 0, 0, 0, 0, 0);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      bit av, al, ac, bv, bl, bc;
      av = ($urandom_range(0, 9) < 7);
      al = ($urandom_range(0, 3) == 0) || (m_len[0] > 60);
      ac = ($urandom_range(0, 39) == 0);
      bv = ($urandom_range(0, 9) < 7);
      bl = ($urandom_range(0, 5) == 0) || (m_len[1] > 60);
      bc = ($urandom_range(0, 39) == 0);
      cyc(av, al, ac, int'($urandom_range(0, 1)), bv, bl, bc, int'($urandom_range(0, 3)));
      chkm(0, "rand");
      chkm(1, "rand");
    end
    rv = 0; rl = 0; rc = 0;
    cyc(rv, rl, rc, 0, rv, rl, rc, 0);
    chkm(0, "rand_tail");
    chkm(1, "rand_tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
